// File: rtl/bounce_emulator.sv
// Synthetic switch-bounce source: turns a clean level request into a bouncing level that settles on it.
// Define BOUNCE_FIXED_INTERVAL_EN for a fixed 2**INTERVAL_W toggle spacing instead of LFSR-random spacing.
//
// state  | meaning
// IDLE   | output equals request, waiting for a new level
// BOUNCE | emitting the toggle burst, counter times the next toggle
// SETTLE | output held at target, counter times the quiet period
module bounce_emulator #(
   parameter int          PAIRS      = 3,
   parameter int          INTERVAL_W = 4,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       press,
   output logic       bouncy,
   output logic       busy,
   output logic       settled,
   output logic [7:0] toggles
);

   localparam int CNT_W = INTERVAL_W + 1;
   localparam int REM_W = $clog2(2 * PAIRS + 2);
   localparam logic [CNT_W-1:0] FULL     = {1'b1, {INTERVAL_W{1'b0}}};
   localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   state_t           state, state_n;
   logic [15:0]      lfsr;
   logic             fb;
   logic [CNT_W-1:0] cnt, cnt_n, interval;
   logic [REM_W-1:0] rem, rem_n;
   logic             target, target_n;
   logic             bouncy_n, busy_n, settled_n;
   logic [7:0]       toggles_n;

   assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef BOUNCE_FIXED_INTERVAL_EN
   assign interval = FULL;
`else
   assign interval = {1'b0, lfsr[INTERVAL_W-1:0]} + CNT_W'(1);
`endif

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rem_n     = rem;
      target_n  = target;
      bouncy_n  = bouncy;
      busy_n    = busy;
      settled_n = 1'b0;
      case (state)
         IDLE: begin
            if (press != bouncy) begin
               target_n = press;
               bouncy_n = ~bouncy;
               busy_n   = 1'b1;
               if (PAIRS == 0) begin
                  state_n = SETTLE;
                  cnt_n   = FULL;
               end else begin
                  rem_n   = REM_W'(2 * PAIRS);
                  state_n = BOUNCE;
                  cnt_n   = interval;
               end
            end
         end
         BOUNCE: begin
            if (cnt == CNT_W'(1)) begin
               rem_n = rem - REM_W'(1);
               if (rem == REM_W'(1)) begin
                  // odd toggle count makes ~bouncy == target here; use target to pin it
                  bouncy_n = target;
                  state_n  = SETTLE;
                  cnt_n    = FULL;
               end else begin
                  bouncy_n = ~bouncy;
                  cnt_n    = interval;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cnt == CNT_W'(1)) begin
               settled_n = 1'b1;
               busy_n    = 1'b0;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      toggles_n = toggles;
      if ((bouncy_n != bouncy) && (toggles != 8'hFF)) toggles_n = toggles + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         target  <= 1'b0;
         bouncy  <= 1'b0;
         busy    <= 1'b0;
         settled <= 1'b0;
         toggles <= 8'd0;
         lfsr    <= SEED_EFF;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rem     <= rem_n;
         target  <= target_n;
         bouncy  <= bouncy_n;
         busy    <= busy_n;
         settled <= settled_n;
         toggles <= toggles_n;
         lfsr    <= {lfsr[14:0], fb};
      end
   end

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: three instances (PAIRS/INTERVAL_W = 3/4, 1/2, 0/2) on one clock.
// Toggle spacing is predicted from a reference LFSR, or fixed when BOUNCE_FIXED_INTERVAL_EN is defined.
module tb_bounce_emulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       press_a = 1'b0, press_b = 1'b0, press_c = 1'b0;
   logic       bouncy_a, busy_a, settled_a;
   logic       bouncy_b, busy_b, settled_b;
   logic       bouncy_c, busy_c, settled_c;
   logic [7:0] toggles_a, toggles_b, toggles_c;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] m_lfsr;
   logic [15:0] hist [0:16383];
   logic        bo   [0:2][0:16383];
   logic        bh   [0:2][0:16383];
   logic        sh   [0:2][0:16383];

   bounce_emulator #(.PAIRS(3), .INTERVAL_W(4)) dut_a (
      .clk(clk), .rst(rst), .press(press_a), .bouncy(bouncy_a),
      .busy(busy_a), .settled(settled_a), .toggles(toggles_a));
   bounce_emulator #(.PAIRS(1), .INTERVAL_W(2)) dut_b (
      .clk(clk), .rst(rst), .press(press_b), .bouncy(bouncy_b),
      .busy(busy_b), .settled(settled_b), .toggles(toggles_b));
   bounce_emulator #(.PAIRS(0), .INTERVAL_W(2)) dut_c (
      .clk(clk), .rst(rst), .press(press_c), .bouncy(bouncy_c),
      .busy(busy_c), .settled(settled_c), .toggles(toggles_c));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   // per-cycle history, taken just after the edge that starts cycle cyc
   always @(posedge clk) begin
      #2;
      if (cyc < 16384) begin
         hist[cyc]  = m_lfsr;
         bo[0][cyc] = bouncy_a;  bh[0][cyc] = busy_a;  sh[0][cyc] = settled_a;
         bo[1][cyc] = bouncy_b;  bh[1][cyc] = busy_b;  sh[1][cyc] = settled_b;
         bo[2][cyc] = bouncy_c;  bh[2][cyc] = busy_c;  sh[2][cyc] = settled_c;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ivl(input int c, input int w);
`ifdef BOUNCE_FIXED_INTERVAL_EN
      return 1 << w;
`else
      int v;
      v = int'(hist[c]);
      return (v & ((1 << w) - 1)) + 1;
`endif
   endfunction

   function automatic int next_edge(input int inst, input int e, input int lim);
      for (int j = e + 1; j <= lim; j++)
         if (bo[inst][j] !== bo[inst][j-1]) return j;
      return -1;
   endfunction

   // transition whose request is first seen by the DUT in cycle 'start'
   task automatic check_transition(input int inst, input int start, input int w, input int pairs,
                                   input logic lvl, input string tag, output int settle);
      int s, e, nxt, hi, stray;
      s = -1;
      for (int j = start + 1; j <= start + 400; j++) begin
         while (j > cyc) @(negedge clk);
         if (sh[inst][j] === 1'b1) begin
            s = j;
            break;
         end
      end
      check({tag, " settle seen"}, (s > 0), 1);
      if (s < 0) s = start + 400;
      settle = s;
      e = start + 1;
      check({tag, " first edge"}, (bo[inst][e] !== bo[inst][start]), 1);
      for (int k = 1; k <= 2 * pairs; k++) begin
         nxt = next_edge(inst, e, s);
         check({tag, " spacing"}, nxt - e, ivl(e - 1, w));
         if (nxt < 0) break;
         e = nxt;
      end
      check({tag, " final level"}, bo[inst][e], lvl);
      check({tag, " quiet settle"}, next_edge(inst, e, s), -1);
      check({tag, " settle time"}, s - e, 1 << w);
      hi = 0;
      stray = 0;
      for (int j = start + 1; j < s; j++) begin
         if (bh[inst][j] === 1'b1) hi++;
         if (sh[inst][j] !== 1'b0) stray++;
      end
      if (bh[inst][start] !== 1'b0) hi += 100;
      if (bh[inst][s] !== 1'b0) hi += 100;
      check({tag, " busy window"}, hi, s - 1 - start);
      check({tag, " single settled"}, stray, 0);
   endtask

   initial begin
      int st, s1, s2, sb, sc, miss, edges;

      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst a", {bouncy_a, busy_a, settled_a, toggles_a}, 0);
         check("rst b", {bouncy_b, busy_b, settled_b, toggles_b}, 0);
         check("rst c", {bouncy_c, busy_c, settled_c, toggles_c}, 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // 0 -> 1 on all three instances at once
      press_a = 1'b1;  press_b = 1'b1;  press_c = 1'b1;
      st = cyc;
      check_transition(2, st, 2, 0, 1'b1, "c rise", sc);
      check_transition(1, st, 2, 1, 1'b1, "b rise", sb);
      check_transition(0, st, 4, 3, 1'b1, "a rise", s1);
      check("b toggles", toggles_b, 3);
      check("c toggles", toggles_c, 1);
      check("a toggles", toggles_a, 7);
      repeat (20) @(negedge clk);
      check("a idle stays", {bouncy_a, busy_a, 8'(next_edge(0, s1, cyc))}, {1'b1, 1'b0, 8'hFF});

      // 1 -> 0
      press_a = 1'b0;
      st = cyc;
      check_transition(0, st, 4, 3, 1'b0, "a fall", s1);
      check("a toggles 14", toggles_a, 14);

      // request pulses while busy are ignored
      @(negedge clk);
      press_a = 1'b1;
      st = cyc;
      repeat (3) @(negedge clk);
      press_a = 1'b0;
      repeat (2) @(negedge clk);
      press_a = 1'b1;
      check_transition(0, st, 4, 3, 1'b1, "a pulse", s1);
      repeat (20) @(negedge clk);
      check("a pulse idle", {bouncy_a, busy_a, 8'(next_edge(0, s1, cyc))}, {1'b1, 1'b0, 8'hFF});

      // request reverses mid-bounce and is held: two back-to-back transitions
      press_a = 1'b0;
      st = cyc;
      check_transition(0, st, 4, 3, 1'b0, "a pre", s1);
      @(negedge clk);
      press_a = 1'b1;
      st = cyc;
      repeat (4) @(negedge clk);
      press_a = 1'b0;
      check_transition(0, st, 4, 3, 1'b1, "a first", s1);
      check_transition(0, s1, 4, 3, 1'b0, "a second", s2);
      edges = 0;
      for (int j = st + 1; j <= s2; j++) if (bo[0][j] !== bo[0][j-1]) edges++;
      check("a two bursts", edges, 14);

      // reset in the middle of a burst
      @(negedge clk);
      press_a = 1'b1;
      st = cyc;
      repeat (4) @(negedge clk);
      check("a busy pre-rst", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      check("a mid rst", {bouncy_a, busy_a, settled_a, toggles_a}, 0);
      rst = 1'b0;
      st = cyc;
      check_transition(0, st, 4, 3, 1'b1, "a post rst", s1);
      check("a toggles post rst", toggles_a, 7);
      check_transition(2, st, 2, 0, 1'b1, "c post rst", sc);

      // saturate the edge counter on the single-edge instance
      check("c toggles base", toggles_c, 1);
      miss = 0;
      for (int n = 0; n < 256; n++) begin
         @(negedge clk);
         press_c = ~press_c;
         @(negedge clk);
         for (int k = 0; k < 20 && settled_c !== 1'b1; k++) @(negedge clk);
         if (settled_c !== 1'b1) miss++;
         if (n == 252) check("c toggles 254", toggles_c, 254);
      end
      check("c sat timeouts", miss, 0);
      check("c toggles sat", toggles_c, 255);
      check("c level", bouncy_c, press_c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog observed timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
